rom_port_arbiter: RTL
=====================

// Module: rom_port_arbiter
// PURPOSE
// - Shares the two registered read ports of a pattern-lookup ROM (1-cycle read latency) among NREQ requesters.
// - Grants up to two requests per cycle, round-robin, and drives the ROM port addresses from a registered stage.
// - Tags each read in flight and returns the ROM data to the requester that issued it.
// - Sits between the pattern-finder lookup clients and one ROM instance. The ROM itself stays a pure storage block.
// PARAMETERS
// - NREQ      4   number of requesters (2..8)
// - MXADRB    12  ROM address width
// - MXDATB    9   ROM data width
// - ROM_LAT   1   ROM read latency in clocks, adr registered -> rd valid
// PORTS
// - clock        in   1            system clock, all logic on posedge
// - reset_n      in   1            asynchronous active-low reset
// - req          in   NREQ         per-requester read request, held until granted
// - req_adr      in   NREQ*MXADRB  per-requester address, slice i = [i*MXADRB +: MXADRB]
// - gnt          out  NREQ         grant, combinational from req and the rr pointer
// - rsp_valid    out  NREQ         one-cycle pulse, rsp_data slice valid
// - rsp_data     out  NREQ*MXDATB  per-requester returned data, held until that requester's next response
// - rom_adr0     out  MXADRB       to ROM adr0, registered
// - rom_adr1     out  MXADRB       to ROM adr1, registered
// - rom_rd0      in   MXDATB       from ROM rd0
// - rom_rd1      in   MXDATB       from ROM rd1
// - busy         out  1            any read in flight, or any req pending
// - stat_grants  out  16           grant counter (only with ROMARB_STATS_EN)
// - stat_stalls  out  16           stall counter (only with ROMARB_STATS_EN)
// BEHAVIOUR
// - Reset values: gnt=0, rsp_valid=0, rsp_data=0, rom_adr0/1=0, busy=0, rr pointer=0, tag pipe cleared, stat counters=0.
// - Arbitration (combinational, cycle T):
//   - Scan requesters from rr_ptr upward, wrapping modulo NREQ.
//   - The first requester with req=1 gets port 0; the second gets port 1. At most 2 bits of gnt are set.
//   - A single requester gets port 0 only. No requester is ever granted both ports.
// - rr_ptr update at the edge ending T:
//   - If any grant was given, rr_ptr <= (index of last granted) + 1, modulo NREQ.
//   - Otherwise rr_ptr is unchanged.
//   - Starvation bound: a pending req is granted within ceil(NREQ/2)-1 cycles of waiting.
// - Address stage, edge ending T:
//   - rom_adrN <= req_adr of the requester granted port N.
//   - A port with no grant holds its previous address, so it does not toggle.
//   - Tag pipe stage 0 <= {v0, id0, v1, id1}, where id = clog2(NREQ) bits.
// - The tag pipe is 1+ROM_LAT stages deep. It advances every clock and has no stall.
// - Response:
//   - When the final tag stage has v0, rsp_data[id0] <= rom_rd0 and rsp_valid[id0] pulses for 1 cycle. Port 1 works the same way.
//   - Grant-to-valid latency is fixed at 2+ROM_LAT clocks: gnt in T, rsp_valid in T+3 for ROM_LAT=1.
// - Requester handshake:
//   - The requester must hold req and req_adr stable until it sees gnt=1.
//   - It deasserts req in the cycle after gnt, or keeps req high to issue back-to-back reads.
//   - Multiple outstanding reads per requester are allowed. Responses return in grant order.
// - Identical addresses on both ports in the same cycle are legal. Each requester gets its own copy.
// - rsp_data[i] is not cleared by rsp_valid deassertion. It updates only on a new response to i.
// - Reset mid-operation: all in-flight tags are dropped, no rsp_valid is produced for them, and rr_ptr returns to 0.
// - busy = |req | (OR of all tag-pipe valid bits).
// CONFIGURATION
// - Macro ROMARB_STATS_EN defined:
//   - stat_grants increments by popcount(gnt), i.e. 0, 1 or 2 per clock. It saturates at 16'hFFFF.
//   - stat_stalls increments by 1 in each cycle where popcount(req) > 2, saturating.
//   - Both counters clear on reset only.
// - Macro undefined: stat_grants and stat_stalls are tied to 0 and no counter flops are built.
// TESTING
// - Single: req[2]=1, adr=12'h0A5, ROM[0A5]=9'h1C3 -> gnt[2] in T; rom_adr0=0A5 in T+1; rsp_valid[2] in T+3 with rsp_data[2]=1C3.
// - Pair: req=4'b0011, adrs 0x010/0x020 -> both granted in T (id0 on port 0, id1 on port 1); both rsp_valid pulses in T+3 with correct data.
// - Round-robin fairness: req=4'b1111 held 4 cycles -> grants alternate {0,1},{2,3},{0,1},{2,3}; stat_grants=8, stat_stalls=4 (with ROMARB_STATS_EN).
// - Pointer wrap: rr_ptr=3, req=4'b1001 -> requester 3 on port 0, requester 0 on port 1; next rr_ptr=1.
// - Back-to-back: req[1] held 3 cycles, adrs 0x100,0x101,0x102 -> rsp_valid[1] high in 3 consecutive cycles, data in address order.
// - Reset mid-flight: grant in T, reset_n low in T+1 for 1 cycle -> no rsp_valid ever appears for that read; all outputs return to reset values; busy=0.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing the two registered read ports of a 1-cycle ROM among NREQ clients.
// Optional grant/stall statistics counters are built when ROMARB_STATS_EN is defined.
module rom_port_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MXADRB  = 12,
  parameter int unsigned MXDATB  = 9,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*MXADRB-1:0]   req_adr,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [NREQ*MXDATB-1:0]   rsp_data,
  output logic [MXADRB-1:0]        rom_adr0,
  output logic [MXADRB-1:0]        rom_adr1,
  input  logic [MXDATB-1:0]        rom_rd0,
  input  logic [MXDATB-1:0]        rom_rd1,
  output logic                     busy,
  output logic [15:0]              stat_grants,
  output logic [15:0]              stat_stalls
);

  localparam int unsigned IdW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned Stages = 1 + ROM_LAT;
  localparam int unsigned Last   = Stages - 1;

  logic [IdW-1:0]              rr_q, rr_d;
  logic                        v0, v1;
  logic [IdW-1:0]              id0, id1, idx;
  logic [MXADRB-1:0]           adr0_q, adr0_d, adr1_q, adr1_d;
  logic [Stages-1:0]           tv0_q, tv0_d, tv1_q, tv1_d;
  logic [Stages-1:0][IdW-1:0]  tid0_q, tid0_d, tid1_q, tid1_d;
  logic [NREQ-1:0]             rspv_q, rspv_d;
  logic [NREQ*MXDATB-1:0]      rspd_q, rspd_d;

  // Scan from rr_q upward; first hit takes port 0, second takes port 1.
  always_comb begin
    gnt = '0;
    v0  = 1'b0;
    v1  = 1'b0;
    id0 = '0;
    id1 = '0;
    idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IdW'((32'(rr_q) + k) % NREQ);
      if (req[idx]) begin
        if (!v0) begin
          v0       = 1'b1;
          id0      = idx;
          gnt[idx] = 1'b1;
        end else if (!v1) begin
          v1       = 1'b1;
          id1      = idx;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (v1) begin
      rr_d = IdW'((32'(id1) + 1) % NREQ);
    end else if (v0) begin
      rr_d = IdW'((32'(id0) + 1) % NREQ);
    end else begin
      rr_d = rr_q;
    end
  end

  // Address stage and tag pipe; ungranted ports hold their last address.
  always_comb begin
    adr0_d = adr0_q;
    adr1_d = adr1_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (v0 && id0 == IdW'(i)) adr0_d = req_adr[i*MXADRB +: MXADRB];
      if (v1 && id1 == IdW'(i)) adr1_d = req_adr[i*MXADRB +: MXADRB];
    end
    tv0_d     = tv0_q;
    tv1_d     = tv1_q;
    tid0_d    = tid0_q;
    tid1_d    = tid1_q;
    tv0_d[0]  = v0;
    tv1_d[0]  = v1;
    tid0_d[0] = id0;
    tid1_d[0] = id1;
    for (int unsigned s = 1; s < Stages; s++) begin
      tv0_d[s]  = tv0_q[s-1];
      tv1_d[s]  = tv1_q[s-1];
      tid0_d[s] = tid0_q[s-1];
      tid1_d[s] = tid1_q[s-1];
    end
  end

  // Return stage: the last tag stage lines up with the ROM read data.
  always_comb begin
    rspv_d = '0;
    rspd_d = rspd_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (tv0_q[Last] && tid0_q[Last] == IdW'(i)) begin
        rspv_d[i]                  = 1'b1;
        rspd_d[i*MXDATB +: MXDATB] = rom_rd0;
      end
      if (tv1_q[Last] && tid1_q[Last] == IdW'(i)) begin
        rspv_d[i]                  = 1'b1;
        rspd_d[i*MXDATB +: MXDATB] = rom_rd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q   <= '0;
      adr0_q <= '0;
      adr1_q <= '0;
      tv0_q  <= '0;
      tv1_q  <= '0;
      tid0_q <= '0;
      tid1_q <= '0;
      rspv_q <= '0;
      rspd_q <= '0;
    end else begin
      rr_q   <= rr_d;
      adr0_q <= adr0_d;
      adr1_q <= adr1_d;
      tv0_q  <= tv0_d;
      tv1_q  <= tv1_d;
      tid0_q <= tid0_d;
      tid1_q <= tid1_d;
      rspv_q <= rspv_d;
      rspd_q <= rspd_d;
    end
  end

  assign rom_adr0  = adr0_q;
  assign rom_adr1  = adr1_q;
  assign rsp_valid = rspv_q;
  assign rsp_data  = rspd_q;
  assign busy      = (|req) | (|tv0_q) | (|tv1_q);

`ifdef ROMARB_STATS_EN
  logic [15:0] sg_q, sg_d, ss_q, ss_d;
  logic [16:0] sg_sum;

  always_comb begin
    sg_sum = {1'b0, sg_q} + 17'(v0) + 17'(v1);
    sg_d   = sg_sum[16] ? 16'hFFFF : sg_sum[15:0];
    ss_d   = ss_q;
    if ($countones(req) > 2 && ss_q != 16'hFFFF) ss_d = ss_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sg_q <= '0;
      ss_q <= '0;
    end else begin
      sg_q <= sg_d;
      ss_q <= ss_d;
    end
  end

  assign stat_grants = sg_q;
  assign stat_stalls = ss_q;
`else
  assign stat_grants = '0;
  assign stat_stalls = '0;
`endif

endmodule
